// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector controller: arm, run, count matches, stop at target.
// Define SEQ_DET_OVERLAP_EN for overlapping detection (default build is non-overlapping).
module seq_det_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             x_valid,
    input  logic             x,
    output logic             x_ready,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic [1:0]       state
);

    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [PAT_W-1:0] PAT_RST =
        (PAT_W == 4) ? PAT_W'(4'b1101) : {1'b1, {(PAT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ARM  = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t             state_reg, state_next;
    logic [PAT_W-2:0]   hist_reg;
    logic [FILL_W-1:0]  fill_reg;
    logic [PAT_W-1:0]   pat_reg;
    logic [CNT_W-1:0]   target_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               match_reg;
    logic               done_reg;

    logic [PAT_W-1:0]   win;
    logic [PAT_W-1:0]   bit_eq;
    logic               accept;
    logic               hit;
    logic [CNT_W-1:0]   cnt_inc;
    logic               reached;

    assign accept  = x_valid && (state_reg == S_RUN);
    assign win     = {hist_reg, x};
    assign cnt_inc = cnt_reg + CNT_W'(1);
    assign reached = (target_reg != '0) && (cnt_inc == target_reg);

    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign bit_eq[gi] = win[gi] ~^ pat_reg[gi];
        end
    endgenerate

    // An abort in the same cycle discards the accepted bit entirely.
    assign hit = accept && !abort && (&bit_eq) && (fill_reg == FILL_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (start) state_next = S_ARM;
            S_ARM:  state_next = abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (abort)
                    state_next = S_IDLE;
                else if (hit && reached)
                    state_next = S_DONE;
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        x_ready = (state_reg == S_RUN);
        busy    = (state_reg == S_ARM) || (state_reg == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_reg   <= '0;
            fill_reg   <= '0;
            pat_reg    <= PAT_RST;
            target_reg <= CNT_W'(1);
            cnt_reg    <= '0;
            match_reg  <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            match_reg <= 1'b0;
            done_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cfg_we) begin
                        pat_reg    <= cfg_pat;
                        target_reg <= cfg_target;
                    end
                end
                S_ARM: begin
                    hist_reg <= '0;
                    fill_reg <= '0;
                    cnt_reg  <= '0;
                end
                S_RUN: begin
                    if (accept && !abort) begin
                        if (hit) begin
                            match_reg <= 1'b1;
                            done_reg  <= reached;
                            cnt_reg   <= cnt_inc;
`ifdef SEQ_DET_OVERLAP_EN
                            hist_reg  <= win[PAT_W-2:0];
`else
                            hist_reg  <= '0;
                            fill_reg  <= '0;
`endif
                        end else begin
                            hist_reg <= win[PAT_W-2:0];
                            if (fill_reg != FILL_MAX)
                                fill_reg <= fill_reg + FILL_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign match     = match_reg;
    assign done      = done_reg;
    assign match_cnt = cnt_reg;
    assign state     = state_reg;

endmodule
